// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// master: the control FSM (consumes opcode/mem_ready, drives selects and strobes).
// slave:  the datapath/memory side.
interface multicycle_control_fsm_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output state, ir_write, pc_write, pc_write_cond, pc_source, iord, mem_read,
               mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               halted, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  state, ir_write, pc_write, pc_write_cond, pc_source, iord, mem_read,
               mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               halted, illegal_op
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the 16-bit multicycle CPU: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Outputs are combinational from state and opcode and forced to 0 while reset is high.
// Optional feature macro: MEM_WAIT_EN -- FETCH and MEM wait for mem_ready, with a
// MEM_TIMEOUT-cycle watchdog that parks the FSM in HALT.
module multicycle_control_fsm #(
    parameter logic [3:0]  OPC_HALT    = 4'b1111,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsR, ClsShift, ClsLw, ClsSw, ClsBeq, ClsImm, ClsHalt, ClsIllegal
    } op_cls_e;

    state_e  state_q, state_d;
    op_cls_e cls;
    logic    mem_ok;
    logic    timeout;

    logic       ir_write, pc_write, pc_write_cond, pc_source, iord;
    logic       mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       halted, illegal_op;

    // Classify the opcode; HALT is checked first so OPC_HALT wins over any overlap.
    always_comb begin
        cls = ClsIllegal;
        if (bus.opcode == OPC_HALT) begin
            cls = ClsHalt;
        end else begin
            case (bus.opcode)
                4'b0000:                   cls = ClsR;
                4'b0010:                   cls = ClsShift;
                4'b0001:                   cls = ClsLw;
                4'b0011:                   cls = ClsSw;
                4'b0101:                   cls = ClsBeq;
                4'b1001, 4'b1010, 4'b1011: cls = ClsImm;
                default:                   cls = ClsIllegal;
            endcase
        end
    end

`ifdef MEM_WAIT_EN
    logic [7:0] wait_cnt_q;

    assign mem_ok  = bus.mem_ready;
    assign timeout = (wait_cnt_q == 8'(MEM_TIMEOUT - 1));

    // Wait counter: cleared on every state change, counts cycles spent stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 8'd0;
        end else if (state_d != state_q) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == StFetch || state_q == StMem) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end
`else
    logic unused_wait_cfg;

    assign mem_ok          = 1'b1;
    assign timeout         = 1'b0;
    assign unused_wait_cfg = bus.mem_ready ^ (MEM_TIMEOUT == 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready in the timeout cycle takes priority over the halt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ok)       state_d = StDecode;
                else if (timeout) state_d = StHalt;
            end
            StDecode: begin
                if (cls == ClsHalt)         state_d = StHalt;
                else if (cls == ClsIllegal) state_d = StFetch;
                else                        state_d = StExec;
            end
            StExec: begin
                case (cls)
                    ClsR, ClsShift, ClsImm: state_d = StWb;
                    ClsLw, ClsSw:           state_d = StMem;
                    default:                state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ok)       state_d = (cls == ClsLw) ? StWb : StFetch;
                else if (timeout) state_d = StHalt;
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Output decode from state and opcode class; everything quiet while in reset.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        halted        = 1'b0;
        illegal_op    = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                    alu_src_b = 2'b01;
                end
                StDecode: begin
                    // Branch target into ALUOut ahead of a possible BEQ.
                    alu_src_b  = 2'b11;
                    illegal_op = (cls == ClsIllegal);
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    case (cls)
                        ClsR:     alu_op = 2'b10;
                        ClsShift: alu_op = 2'b11;
                        ClsImm: begin
                            alu_src_b = 2'b10;
                            alu_op    = 2'b11;
                        end
                        ClsLw, ClsSw: alu_src_b = 2'b10;
                        ClsBeq: begin
                            alu_op        = 2'b01;
                            pc_write_cond = 1'b1;
                            pc_source     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    iord      = 1'b1;
                    mem_read  = (cls == ClsLw);
                    mem_write = (cls == ClsSw);
                end
                StWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls == ClsR) || (cls == ClsShift);
                    mem_to_reg = (cls == ClsLw);
                end
                StHalt:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state         = state_q;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_source     = pc_source;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.reg_write     = reg_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.halted        = halted;
    assign bus.illegal_op    = illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. The driver expands each instruction into
// its expected per-cycle output trace and queues it; a negedge monitor pops and compares.
// Build with +define+MEM_WAIT_EN to also exercise the memory wait / timeout behaviour.
module tb_multicycle_control_fsm;

    localparam int unsigned TO = 15;

    localparam int K_R    = 0;
    localparam int K_SH   = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_BEQ  = 4;
    localparam int K_IMM  = 5;
    localparam int K_HALT = 6;
    localparam int K_ILL  = 7;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
        logic       illegal_op;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t exp_q[$];
    vec_t plan_v[$];
    logic plan_r[$];

    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(
        .OPC_HALT   (4'b1111),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Instruction class straight from the opcode table.
    function automatic int kind_of(logic [3:0] op);
        case (op)
            4'b0000:                   return K_R;
            4'b0010:                   return K_SH;
            4'b0001:                   return K_LW;
            4'b0011:                   return K_SW;
            4'b0101:                   return K_BEQ;
            4'b1001, 4'b1010, 4'b1011: return K_IMM;
            4'b1111:                   return K_HALT;
            default:                   return K_ILL;
        endcase
    endfunction

    task automatic add(input vec_t v, input logic r);
        plan_v.push_back(v);
        plan_r.push_back(r);
    endtask

    // A memory phase: 'lows' not-ready cycles, then the completing cycle, unless the
    // watchdog fires first (TO not-ready cycles in a row).
    task automatic mem_phase(input vec_t busy, input vec_t done, input int lows,
                             output bit hung);
        hung = 1'b0;
`ifdef MEM_WAIT_EN
        for (int i = 0; i < lows && i < int'(TO); i++) add(busy, 1'b0);
        if (lows >= int'(TO)) hung = 1'b1;
        else                  add(done, 1'b1);
`else
        if (busy.st == 3'd7) hung = 1'b1;
        add(done, 1'($urandom));
`endif
    endtask

    // Expected trace of one instruction from FETCH; to_halt set if it ends in HALT.
    task automatic build_instr(input logic [3:0] op, input int fl, input int ml,
                               output bit to_halt);
        vec_t busy, done, v;
        bit   hung;
        int   k = kind_of(op);
        to_halt = 1'b0;
        busy = '0;
        busy.mem_read  = 1'b1;
        busy.alu_src_b = 2'b01;
        done = busy;
        done.ir_write = 1'b1;
        done.pc_write = 1'b1;
        mem_phase(busy, done, fl, hung);
        if (hung) begin
            to_halt = 1'b1;
            return;
        end
        v = '0;
        v.st         = 3'd1;
        v.alu_src_b  = 2'b11;
        v.illegal_op = (k == K_ILL);
        add(v, 1'($urandom));
        if (k == K_HALT) begin
            to_halt = 1'b1;
            return;
        end
        if (k == K_ILL) return;
        v = '0;
        v.st        = 3'd2;
        v.alu_src_a = 1'b1;
        case (k)
            K_R:  v.alu_op = 2'b10;
            K_SH: v.alu_op = 2'b11;
            K_IMM: begin
                v.alu_src_b = 2'b10;
                v.alu_op    = 2'b11;
            end
            K_LW, K_SW: v.alu_src_b = 2'b10;
            default: begin
                v.alu_op        = 2'b01;
                v.pc_write_cond = 1'b1;
                v.pc_source     = 1'b1;
            end
        endcase
        add(v, 1'($urandom));
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            busy = '0;
            busy.st        = 3'd3;
            busy.iord      = 1'b1;
            busy.mem_read  = (k == K_LW);
            busy.mem_write = (k == K_SW);
            mem_phase(busy, busy, ml, hung);
            if (hung) begin
                to_halt = 1'b1;
                return;
            end
            if (k == K_SW) return;
        end
        v = '0;
        v.st         = 3'd4;
        v.reg_write  = 1'b1;
        v.reg_dst    = (k == K_R) || (k == K_SH);
        v.mem_to_reg = (k == K_LW);
        add(v, 1'($urandom));
    endtask

    // Queue the planned expectations, then play the planned mem_ready one cycle each.
    task automatic run_plan();
        foreach (plan_v[i]) exp_q.push_back(plan_v[i]);
        foreach (plan_r[i]) begin
            bus.mem_ready = plan_r[i];
            @(posedge clk);
            #2;
        end
        plan_v.delete();
        plan_r.delete();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) add('0, 1'($urandom));
        run_plan();
        reset = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input int fl, input int ml, input int hold);
        bit   h;
        vec_t v;
        bus.opcode = op;
        build_instr(op, fl, ml, h);
        run_plan();
        if (h) begin
            v = '0;
            v.st     = 3'd5;
            v.halted = 1'b1;
            for (int i = 0; i < hold; i++) add(v, 1'($urandom));
            run_plan();
            do_reset(1 + int'($urandom_range(0, 2)));
        end
    endtask

    // Monitor: one comparison per expected cycle, plus the read/write exclusivity rule.
    always @(negedge clk) begin
        vec_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.st            = bus.state;
            a.ir_write      = bus.ir_write;
            a.pc_write      = bus.pc_write;
            a.pc_write_cond = bus.pc_write_cond;
            a.pc_source     = bus.pc_source;
            a.iord          = bus.iord;
            a.mem_read      = bus.mem_read;
            a.mem_write     = bus.mem_write;
            a.reg_write     = bus.reg_write;
            a.reg_dst       = bus.reg_dst;
            a.mem_to_reg    = bus.mem_to_reg;
            a.alu_src_a     = bus.alu_src_a;
            a.alu_src_b     = bus.alu_src_b;
            a.alu_op        = bus.alu_op;
            a.halted        = bus.halted;
            a.illegal_op    = bus.illegal_op;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t op=%b got st=%0d vec=%h want st=%0d vec=%h",
                         $time, bus.opcode, a.st, a, e.st, e);
            end
            n_vec++;
            if ((bus.mem_read & bus.mem_write) !== 1'b0) begin
                n_err++;
                $display("FAIL rd_wr_excl t=%0t got mem_read=%b mem_write=%b want not both",
                         $time, bus.mem_read, bus.mem_write);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.opcode    = 4'b0000;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #2;
        do_reset(2);

        // Directed: R, LW, BEQ, shift, SW, immediates, illegal.
        run_op(4'b0000, 0, 0, 0);
        run_op(4'b0001, 0, 0, 0);
        run_op(4'b0101, 0, 0, 0);
        run_op(4'b0010, 0, 0, 0);
        run_op(4'b0011, 0, 0, 0);
        run_op(4'b1001, 0, 0, 0);
        run_op(4'b1010, 0, 0, 0);
        run_op(4'b1011, 0, 0, 0);
        run_op(4'b0110, 0, 0, 0);

        // Reset in the middle of an ADD's EXEC: no write-back may follow.
        begin
            bit   h;
            vec_t ex;
            bus.opcode = 4'b0000;
            build_instr(4'b0000, 0, 0, h);
            void'(plan_v.pop_back());
            void'(plan_r.pop_back());
            ex = plan_v.pop_back();
            void'(plan_r.pop_back());
            run_plan();
            exp_q.push_back(ex);
            @(negedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #2;
            do_reset(1);
        end
        run_op(4'b0000, 0, 0, 0);

        // HALT held for 20 cycles, then released only by reset.
        run_op(4'b1111, 0, 0, 20);
        run_op(4'b0001, 0, 0, 0);

`ifdef MEM_WAIT_EN
        run_op(4'b0011, 0, 3, 0);
        run_op(4'b0011, 0, 15, 4);
        run_op(4'b0011, 0, 14, 0);
        run_op(4'b0001, 2, 5, 0);
        run_op(4'b0000, 15, 0, 3);
        run_op(4'b0101, 14, 0, 0);
`endif

        // Randomized instruction stream, including random wait lengths when enabled.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            int         fl, ml;
            op = 4'($urandom_range(0, 15));
`ifdef MEM_WAIT_EN
            fl = int'($urandom_range(0, 3));
            ml = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 4));
`else
            fl = 0;
            ml = 0;
`endif
            run_op(op, fl, ml, 2 + int'($urandom_range(0, 5)));
        end

        repeat (2) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
